// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : RV32IM execute stage - ALU, branch/jump resolution, single-cycle
//            multiply, iterative restoring divide and the EX/MEM register.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            flush,
    input  logic            valid_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [4:0]      rd_in,
    input  logic [2:0]      funct3_in,
    input  logic [3:0]      alu_op_in,
    input  logic            alu_src_a_pc_in,
    input  logic            alu_src_b_imm_in,
    input  logic            md_en_in,
    input  logic            branch_in,
    input  logic            jal_in,
    input  logic            jalr_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            reg_write_in,
    input  logic [1:0]      wb_sel_in,
    output logic            ex_busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] rs2_data_out,
    output logic [4:0]      rd_out,
    output logic [2:0]      funct3_out,
    output logic            valid_out,
    output logic            mem_read_out,
    output logic            mem_write_out,
    output logic            reg_write_out,
    output logic [1:0]      wb_sel_out
);

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_SLL  = 4'd2;
    localparam logic [3:0] c_ALU_SLT  = 4'd3;
    localparam logic [3:0] c_ALU_SLTU = 4'd4;
    localparam logic [3:0] c_ALU_XOR  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_OR   = 4'd8;
    localparam logic [3:0] c_ALU_AND  = 4'd9;
    localparam logic [3:0] c_ALU_PASS = 4'd10;

    localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    // ------------------------------------------------------------------ ALU
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu;

    assign w_op_a  = alu_src_a_pc_in  ? pc_in  : rs1_data_in;
    assign w_op_b  = alu_src_b_imm_in ? imm_in : rs2_data_in;
    assign w_shamt = w_op_b[4:0];

    always_comb begin
        w_alu = '0;
        case (alu_op_in)
            c_ALU_ADD:  w_alu = w_op_a + w_op_b;
            c_ALU_SUB:  w_alu = w_op_a - w_op_b;
            c_ALU_SLL:  w_alu = w_op_a << w_shamt;
            c_ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            c_ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
            c_ALU_XOR:  w_alu = w_op_a ^ w_op_b;
            c_ALU_SRL:  w_alu = w_op_a >> w_shamt;
            c_ALU_SRA:  w_alu = $signed(w_op_a) >>> w_shamt;
            c_ALU_OR:   w_alu = w_op_a | w_op_b;
            c_ALU_AND:  w_alu = w_op_a & w_op_b;
            c_ALU_PASS: w_alu = w_op_b;
            default:    w_alu = '0;
        endcase
    end

    // ------------------------------------------------------ branch / jump
    logic            w_br_cond;
    logic            w_taken;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_link;

    always_comb begin
        w_br_cond = 1'b0;
        case (funct3_in)
            3'b000:  w_br_cond = (rs1_data_in == rs2_data_in);
            3'b001:  w_br_cond = (rs1_data_in != rs2_data_in);
            3'b100:  w_br_cond = ($signed(rs1_data_in) <  $signed(rs2_data_in));
            3'b101:  w_br_cond = ($signed(rs1_data_in) >= $signed(rs2_data_in));
            3'b110:  w_br_cond = (rs1_data_in <  rs2_data_in);
            3'b111:  w_br_cond = (rs1_data_in >= rs2_data_in);
            default: w_br_cond = 1'b0;
        endcase
    end

    assign w_taken        = jal_in | jalr_in | (branch_in & w_br_cond);
    assign w_jalr_sum     = rs1_data_in + imm_in;
    assign w_link         = pc_in + XLEN'(4);
    assign redirect_pc    = jalr_in ? {w_jalr_sum[XLEN-1:1], 1'b0} : (pc_in + imm_in);
    assign redirect_valid = valid_in & w_taken & ~ex_busy & ~stall_in & ~flush;

    // ------------------------------------------------------------ multiply
    // 33-bit operands sign-extended to 2*XLEN; the low 2*XLEN bits of the
    // product are exact for every signedness combination.
    logic                w_mul_a_sgn;
    logic                w_mul_b_sgn;
    logic [2*XLEN-1:0]   w_mul_a;
    logic [2*XLEN-1:0]   w_mul_b;
    logic [2*XLEN-1:0]   w_mul_prod;
    logic [XLEN-1:0]     w_mul_res;

    assign w_mul_a_sgn = (funct3_in[1:0] != 2'b11) & rs1_data_in[XLEN-1];
    assign w_mul_b_sgn = ~funct3_in[1] & rs2_data_in[XLEN-1];
    assign w_mul_a     = {{XLEN{w_mul_a_sgn}}, rs1_data_in};
    assign w_mul_b     = {{XLEN{w_mul_b_sgn}}, rs2_data_in};
    assign w_mul_prod  = w_mul_a * w_mul_b;
    assign w_mul_res   = (funct3_in[1:0] == 2'b00) ? w_mul_prod[XLEN-1:0]
                                                   : w_mul_prod[2*XLEN-1:XLEN];

    // -------------------------------------------------------------- divide
    div_state_t      r_state;
    logic [4:0]      r_count;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_divisor;
    logic            r_neg_quot;
    logic            r_neg_rem;
    logic            r_div_is_rem;

    logic            w_is_div;
    logic            w_div_signed;
    logic            w_dvd_neg;
    logic            w_dvs_neg;
    logic [XLEN-1:0] w_dvd_abs;
    logic [XLEN-1:0] w_dvs_abs;
    logic            w_div_by_zero;
    logic            w_div_ovf;
    logic [XLEN:0]   w_rem_shift;
    logic [XLEN:0]   w_rem_diff;
    logic [XLEN-1:0] w_div_res;

    assign w_is_div      = md_en_in & funct3_in[2];
    assign w_div_signed  = ~funct3_in[0];
    assign w_dvd_neg     = w_div_signed & rs1_data_in[XLEN-1];
    assign w_dvs_neg     = w_div_signed & rs2_data_in[XLEN-1];
    assign w_dvd_abs     = w_dvd_neg ? -rs1_data_in : rs1_data_in;
    assign w_dvs_abs     = w_dvs_neg ? -rs2_data_in : rs2_data_in;
    assign w_div_by_zero = (rs2_data_in == '0);
    assign w_div_ovf     = w_div_signed & (rs1_data_in == c_INT_MIN) & (&rs2_data_in);

    // r_quot shifts dividend bits out of the top while quotient bits enter at the bottom
    assign w_rem_shift = {r_rem, r_quot[XLEN-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_divisor};

    assign w_div_res = r_div_is_rem ? (r_neg_rem  ? -r_rem  : r_rem)
                                    : (r_neg_quot ? -r_quot : r_quot);

    assign ex_busy = valid_in & w_is_div & (r_state != S_DONE);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_quot       <= '0;
            r_rem        <= '0;
            r_divisor    <= '0;
            r_neg_quot   <= 1'b0;
            r_neg_rem    <= 1'b0;
            r_div_is_rem <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_in && w_is_div) begin
                        r_div_is_rem <= funct3_in[1];
                        r_count      <= '0;
                        if (w_div_by_zero) begin
                            r_quot     <= '1;
                            r_rem      <= rs1_data_in;
                            r_neg_quot <= 1'b0;
                            r_neg_rem  <= 1'b0;
                            r_state    <= S_DONE;
                        end else if (w_div_ovf) begin
                            r_quot     <= c_INT_MIN;
                            r_rem      <= '0;
                            r_neg_quot <= 1'b0;
                            r_neg_rem  <= 1'b0;
                            r_state    <= S_DONE;
                        end else begin
                            r_quot     <= w_dvd_abs;
                            r_rem      <= '0;
                            r_divisor  <= w_dvs_abs;
                            r_neg_quot <= w_dvd_neg ^ w_dvs_neg;
                            r_neg_rem  <= w_dvd_neg;
                            r_state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (!(valid_in && w_is_div)) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (!w_rem_diff[XLEN]) begin
                            r_rem  <= w_rem_diff[XLEN-1:0];
                            r_quot <= {r_quot[XLEN-2:0], 1'b1};
                        end else begin
                            r_rem  <= w_rem_shift[XLEN-1:0];
                            r_quot <= {r_quot[XLEN-2:0], 1'b0};
                        end
                        r_count <= r_count + 5'd1;
                        if (r_count == 5'd31) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!(valid_in && w_is_div) || !stall_in) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------ EX/MEM register
    logic [XLEN-1:0] w_result;

    assign w_result = (jal_in || jalr_in) ? w_link
                    : md_en_in            ? (funct3_in[2] ? w_div_res : w_mul_res)
                    :                       w_alu;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alu_result_out <= '0;
            rs2_data_out   <= '0;
            rd_out         <= '0;
            funct3_out     <= '0;
            valid_out      <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            reg_write_out  <= 1'b0;
            wb_sel_out     <= '0;
        end else if (stall_in) begin
            // hold everything
        end else if (ex_busy) begin
            valid_out      <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            reg_write_out  <= 1'b0;
        end else begin
            alu_result_out <= w_result;
            rs2_data_out   <= rs2_data_in;
            rd_out         <= rd_in;
            funct3_out     <= funct3_in;
            valid_out      <= valid_in;
            mem_read_out   <= mem_read_in  & valid_in;
            mem_write_out  <= mem_write_in & valid_in;
            reg_write_out  <= reg_write_in & valid_in;
            wb_sel_out     <= wb_sel_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Self-checking bench for ex_stage against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall_in, flush, valid_in;
    logic [31:0] pc_in, rs1_data_in, rs2_data_in, imm_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic [3:0]  alu_op_in;
    logic        alu_src_a_pc_in, alu_src_b_imm_in, md_en_in, branch_in, jal_in, jalr_in;
    logic        mem_read_in, mem_write_in, reg_write_in;
    logic [1:0]  wb_sel_in;
    logic        ex_busy, redirect_valid;
    logic [31:0] redirect_pc, alu_result_out, rs2_data_out;
    logic [4:0]  rd_out;
    logic [2:0]  funct3_out;
    logic        valid_out, mem_read_out, mem_write_out, reg_write_out;
    logic [1:0]  wb_sel_out;

    int n_cmp = 0;
    int n_err = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .valid_in(valid_in),
        .pc_in(pc_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .imm_in(imm_in),
        .rd_in(rd_in), .funct3_in(funct3_in), .alu_op_in(alu_op_in),
        .alu_src_a_pc_in(alu_src_a_pc_in), .alu_src_b_imm_in(alu_src_b_imm_in),
        .md_en_in(md_en_in), .branch_in(branch_in), .jal_in(jal_in), .jalr_in(jalr_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
        .wb_sel_in(wb_sel_in), .ex_busy(ex_busy), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .alu_result_out(alu_result_out), .rs2_data_out(rs2_data_out),
        .rd_out(rd_out), .funct3_out(funct3_out), .valid_out(valid_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .reg_write_out(reg_write_out), .wb_sel_out(wb_sel_out)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------ reference model
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return $signed(a) >>> sh;
            8:  return a | b;
            9:  return a & b;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) <  $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a <  b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f3[1:0])
            2'b00, 2'b01: p = sa * sb;
            2'b10:        p = sa * longint'(ub);
            default:      p = ua * ub;
        endcase
        return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int  sa, sb;
        bit  ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_div_busy(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------------------------------------------------- stimulus
    task automatic clear_in();
        stall_in = 0; flush = 0; valid_in = 0; pc_in = 0; rs1_data_in = 0; rs2_data_in = 0;
        imm_in = 0; rd_in = 0; funct3_in = 0; alu_op_in = 0; alu_src_a_pc_in = 0;
        alu_src_b_imm_in = 0; md_en_in = 0; branch_in = 0; jal_in = 0; jalr_in = 0;
        mem_read_in = 0; mem_write_in = 0; reg_write_in = 0; wb_sel_in = 0;
    endtask

    // Runs one divide to completion and returns what was observed.
    task automatic run_div(input bit drive, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] res, output int busy,
                           output int bad_bubbles, output logic res_valid);
        if (drive) begin
            @(negedge clk);
            clear_in();
            valid_in = 1; md_en_in = 1; funct3_in = f3; rs1_data_in = a; rs2_data_in = b;
            reg_write_in = 1; rd_in = 5'd9;
        end
        busy = 0;
        bad_bubbles = 0;
        #1;
        while (ex_busy === 1'b1 && busy < 100) begin
            busy++;
            @(negedge clk);
            #1;
            if (valid_out !== 1'b0) bad_bubbles++;
        end
        @(negedge clk);
        res = alu_result_out;
        res_valid = valid_out;
        clear_in();
    endtask

    // -------------------------------------------------------------- tests
    task automatic test_reset();
        clear_in();
        rst = 1; jal_in = 1; md_en_in = 1; funct3_in = 3'b100; rs1_data_in = 32'd9; rs2_data_in = 32'd3;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({alu_result_out, rs2_data_out, rd_out, funct3_out, valid_out, mem_read_out,
             mem_write_out, reg_write_out, wb_sel_out} !== '0) begin
            n_err++; $display("FAIL reset_regs: got res=%h v=%b rw=%b expected all zero", alu_result_out, valid_out, reg_write_out);
        end
        n_cmp++;
        if (ex_busy !== 1'b0 || redirect_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_idle_outs: got busy=%b redir=%b expected 0 0", ex_busy, redirect_valid);
        end
        @(negedge clk);
        rst = 0;
        clear_in();
    endtask

    task automatic test_alu();
        int          ops[9]  = '{0, 7, 1, 3, 4, 2, 6, 10, 13};
        logic [31:0] as[9]   = '{32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'hDEAD_BEEF, 32'h1234};
        logic [31:0] bs[9]   = '{32'hFFFF_FFFD, 32'd4, 32'd1, 32'd1, 32'd1, 32'h23, 32'd31, 32'h1234_5000, 32'h5678};
        logic [31:0] exps[9] = '{32'd2, 32'hF800_0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd8, 32'd1, 32'h1234_5000, 32'd0};
        logic [31:0] exp;
        logic        v;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            clear_in();
            valid_in = 1; reg_write_in = 1; rd_in = 5'd7; wb_sel_in = 2'b01; alu_op_in = 4'(ops[i]);
            rs1_data_in = as[i];
            if (i == 0) begin imm_in = bs[i]; alu_src_b_imm_in = 1; rs2_data_in = 32'hAAAA_0000; end
            else rs2_data_in = bs[i];
            @(negedge clk);
            n_cmp++;
            if (alu_result_out !== exps[i] || valid_out !== 1'b1 || reg_write_out !== 1'b1 || rd_out !== 5'd7) begin
                n_err++; $display("FAIL alu_directed[%0d]: got %h v=%b rw=%b rd=%0d expected %h 1 1 7",
                                  i, alu_result_out, valid_out, reg_write_out, rd_out, exps[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            clear_in();
            v = ($urandom_range(0, 3) != 0);
            valid_in = v; pc_in = $urandom; rs1_data_in = pick_val(); rs2_data_in = pick_val();
            imm_in = $urandom; alu_op_in = 4'($urandom_range(0, 15));
            alu_src_a_pc_in = 1'($urandom_range(0, 1)); alu_src_b_imm_in = 1'($urandom_range(0, 1));
            rd_in = 5'($urandom); funct3_in = 3'($urandom); wb_sel_in = 2'($urandom);
            mem_read_in = 1'($urandom); mem_write_in = 1'($urandom); reg_write_in = 1'($urandom);
            exp = ref_alu(int'(alu_op_in), alu_src_a_pc_in ? pc_in : rs1_data_in,
                          alu_src_b_imm_in ? imm_in : rs2_data_in);
            #1;
            n_cmp++;
            if (redirect_valid !== 1'b0 || ex_busy !== 1'b0) begin
                n_err++; $display("FAIL alu_no_redirect: got redir=%b busy=%b expected 0 0", redirect_valid, ex_busy);
            end
            @(negedge clk);
            n_cmp++;
            if (alu_result_out !== exp) begin
                n_err++; $display("FAIL alu_rand op=%0d: got %h expected %h", alu_op_in, alu_result_out, exp);
            end
            n_cmp++;
            if ({valid_out, mem_read_out, mem_write_out, reg_write_out, rs2_data_out, rd_out, funct3_out, wb_sel_out} !==
                {v, mem_read_in & v, mem_write_in & v, reg_write_in & v, rs2_data_in, rd_in, funct3_in, wb_sel_in}) begin
                n_err++; $display("FAIL alu_ctrl: got v=%b mr=%b mw=%b rw=%b rs2=%h expected v=%b mr=%b mw=%b rw=%b rs2=%h",
                                  valid_out, mem_read_out, mem_write_out, reg_write_out, rs2_data_out,
                                  v, mem_read_in & v, mem_write_in & v, reg_write_in & v, rs2_data_in);
            end
        end
    endtask

    task automatic test_branch();
        bit exp_t;
        // BLT taken, BLTU not taken, then the same BLT blocked by stall, flush, invalid
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_in();
            valid_in = (i != 4); branch_in = 1; pc_in = 32'h100; imm_in = 32'h20;
            rs1_data_in = 32'hFFFF_FFFF; rs2_data_in = 32'd1;
            funct3_in = (i == 1) ? 3'b110 : 3'b100;
            stall_in = (i == 2); flush = (i == 3);
            #1;
            n_cmp++;
            if (redirect_valid !== (i == 0)) begin
                n_err++; $display("FAIL branch_dir[%0d]: got %b expected %b", i, redirect_valid, (i == 0));
            end
            if (i == 0) begin
                n_cmp++;
                if (redirect_pc !== 32'h120) begin
                    n_err++; $display("FAIL blt_target: got %h expected 00000120", redirect_pc);
                end
            end
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            clear_in();
            valid_in = 1; branch_in = 1; funct3_in = 3'($urandom);
            pc_in = $urandom & 32'hFFFF_FFFC; imm_in = $urandom & 32'hFFFF_FFFE;
            rs1_data_in = pick_val();
            rs2_data_in = ($urandom_range(0, 2) == 0) ? rs1_data_in : pick_val();
            exp_t = ref_branch(funct3_in, rs1_data_in, rs2_data_in);
            #1;
            n_cmp++;
            if (redirect_valid !== exp_t || (exp_t && redirect_pc !== pc_in + imm_in)) begin
                n_err++; $display("FAIL branch_rand f3=%0d: got v=%b pc=%h expected v=%b pc=%h",
                                  funct3_in, redirect_valid, redirect_pc, exp_t, pc_in + imm_in);
            end
        end
    endtask

    task automatic test_jump();
        logic [31:0] exp_pc;
        @(negedge clk);
        clear_in();
        valid_in = 1; jalr_in = 1; reg_write_in = 1; rs1_data_in = 32'h203; imm_in = 0; pc_in = 32'h400;
        alu_src_b_imm_in = 1;
        #1;
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h202) begin
            n_err++; $display("FAIL jalr_dir: got v=%b pc=%h expected 1 00000202", redirect_valid, redirect_pc);
        end
        @(negedge clk);
        n_cmp++;
        if (alu_result_out !== 32'h404) begin
            n_err++; $display("FAIL jalr_link: got %h expected 00000404", alu_result_out);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clear_in();
            valid_in = 1; reg_write_in = 1; pc_in = $urandom; imm_in = $urandom; rs1_data_in = $urandom;
            if (i % 2 == 0) jal_in = 1; else jalr_in = 1;
            exp_pc = jal_in ? pc_in + imm_in : (rs1_data_in + imm_in) & 32'hFFFF_FFFE;
            #1;
            n_cmp++;
            if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc) begin
                n_err++; $display("FAIL jump_rand[%0d]: got v=%b pc=%h expected 1 %h", i, redirect_valid, redirect_pc, exp_pc);
            end
            @(negedge clk);
            n_cmp++;
            if (alu_result_out !== pc_in + 32'd4) begin
                n_err++; $display("FAIL jump_link[%0d]: got %h expected %h", i, alu_result_out, pc_in + 32'd4);
            end
        end
    endtask

    task automatic test_mul();
        logic [2:0]  f3s[3]  = '{3'b001, 3'b011, 3'b000};
        logic [31:0] as[3]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps[3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'h0000_0001};
        logic [31:0] exp;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            clear_in();
            valid_in = 1; md_en_in = 1; reg_write_in = 1;
            if (i < 3) begin
                funct3_in = f3s[i]; rs1_data_in = as[i]; rs2_data_in = as[i]; exp = exps[i];
            end else begin
                funct3_in = 3'($urandom_range(0, 3)); rs1_data_in = pick_val(); rs2_data_in = pick_val();
                exp = ref_mul(funct3_in, rs1_data_in, rs2_data_in);
            end
            #1;
            n_cmp++;
            if (ex_busy !== 1'b0) begin
                n_err++; $display("FAIL mul_busy[%0d]: got %b expected 0", i, ex_busy);
            end
            @(negedge clk);
            n_cmp++;
            if (alu_result_out !== exp || valid_out !== 1'b1) begin
                n_err++; $display("FAIL mul[%0d] f3=%0d a=%h b=%h: got %h v=%b expected %h 1",
                                  i, funct3_in, rs1_data_in, rs2_data_in, alu_result_out, valid_out, exp);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3s[10] = '{3'b100, 3'b110, 3'b101, 3'b110, 3'b100, 3'b110, 3'b111, 3'b100, 3'b101, 3'b111};
        logic [31:0] as[10]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000,
                                 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] bs[10]  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
                                 32'h0, 32'h0, 32'h0};
        logic [31:0] exps[6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};
        int          busys[6] = '{33, 33, 1, 1, 1, 1};
        logic [31:0] a, b, res, exp;
        int          busy, bad, exp_busy;
        logic        rv;
        for (int i = 0; i < 10; i++) begin
            a = as[i];
            b = bs[i];
            if (i == 6) a = pick_val();
            if (i >= 7) begin a = pick_val(); b = ($urandom_range(0, 4) == 0) ? 32'h0 : pick_val(); end
            if (i < 6) begin exp = exps[i]; exp_busy = busys[i]; end
            else begin exp = ref_div(f3s[i], a, b); exp_busy = ref_div_busy(f3s[i], a, b); end
            run_div(1'b1, f3s[i], a, b, res, busy, bad, rv);
            n_cmp++;
            if (busy !== exp_busy) begin
                n_err++; $display("FAIL div_busy[%0d]: got %0d cycles expected %0d", i, busy, exp_busy);
            end
            n_cmp++;
            if (res !== exp || rv !== 1'b1) begin
                n_err++; $display("FAIL div_result[%0d] f3=%0d a=%h b=%h: got %h v=%b expected %h 1",
                                  i, f3s[i], a, b, res, rv, exp);
            end
            n_cmp++;
            if (bad !== 0) begin
                n_err++; $display("FAIL div_bubbles[%0d]: got %0d non-bubble cycles expected 0", i, bad);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          busy, bad;
        logic        rv;
        // flush with the divide still presented: must restart from scratch
        @(negedge clk);
        clear_in();
        valid_in = 1; md_en_in = 1; funct3_in = 3'b100; rs1_data_in = 32'd100; rs2_data_in = 32'd7; reg_write_in = 1;
        repeat (10) @(negedge clk);
        flush = 1;
        @(negedge clk);
        n_cmp++;
        if (valid_out !== 1'b0 || reg_write_out !== 1'b0 || alu_result_out !== 32'h0) begin
            n_err++; $display("FAIL flush_regs: got v=%b rw=%b res=%h expected 0 0 0", valid_out, reg_write_out, alu_result_out);
        end
        flush = 0;
        run_div(1'b0, 3'b100, 32'd100, 32'd7, res, busy, bad, rv);
        n_cmp++;
        if (busy !== 33 || res !== 32'd14 || rv !== 1'b1) begin
            n_err++; $display("FAIL flush_restart: got busy=%0d res=%h v=%b expected 33 0000000e 1", busy, res, rv);
        end
        // flush squashing the divide entirely, followed by a normal ADD
        @(negedge clk);
        valid_in = 1; md_en_in = 1; funct3_in = 3'b101; rs1_data_in = 32'd1000; rs2_data_in = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1; valid_in = 0;
        #1;
        n_cmp++;
        if (ex_busy !== 1'b0 || redirect_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_busy: got busy=%b redir=%b expected 0 0", ex_busy, redirect_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_err++; $display("FAIL flush_valid: got %b expected 0", valid_out);
        end
        clear_in();
        valid_in = 1; reg_write_in = 1; rs1_data_in = 32'd3; rs2_data_in = 32'd4;
        @(negedge clk);
        n_cmp++;
        if (alu_result_out !== 32'd7 || valid_out !== 1'b1) begin
            n_err++; $display("FAIL flush_then_add: got %h v=%b expected 00000007 1", alu_result_out, valid_out);
        end
    endtask

    task automatic test_stall();
        int n;
        @(negedge clk);
        clear_in();
        valid_in = 1; reg_write_in = 1; rs1_data_in = 32'd1; rs2_data_in = 32'd2;
        @(negedge clk);
        stall_in = 1; rs1_data_in = 32'd10; rs2_data_in = 32'd20;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (alu_result_out !== 32'd3 || valid_out !== 1'b1) begin
                n_err++; $display("FAIL stall_hold: got %h v=%b expected 00000003 1", alu_result_out, valid_out);
            end
        end
        stall_in = 0;
        @(negedge clk);
        n_cmp++;
        if (alu_result_out !== 32'd30) begin
            n_err++; $display("FAIL stall_release: got %h expected 0000001e", alu_result_out);
        end
        // stall while the divider holds its finished result
        clear_in();
        valid_in = 1; md_en_in = 1; funct3_in = 3'b100; rs1_data_in = 32'd50; rs2_data_in = 32'd5; reg_write_in = 1;
        #1;
        n = 0;
        while (ex_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        stall_in = 1;
        repeat (3) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (valid_out !== 1'b0 || ex_busy !== 1'b0) begin
                n_err++; $display("FAIL stall_done_hold: got v=%b busy=%b expected 0 0", valid_out, ex_busy);
            end
        end
        stall_in = 0;
        @(negedge clk);
        n_cmp++;
        if (alu_result_out !== 32'd10 || valid_out !== 1'b1) begin
            n_err++; $display("FAIL stall_done_release: got %h v=%b expected 0000000a 1", alu_result_out, valid_out);
        end
        clear_in();
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] exp;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp = q.pop_front();
                n_cmp++;
                if (alu_result_out !== exp || valid_out !== 1'b1) begin
                    n_err++; $display("FAIL b2b[%0d]: got %h v=%b expected %h 1", i, alu_result_out, valid_out, exp);
                end
            end
            clear_in();
            if (i < 30) begin
                valid_in = 1; reg_write_in = 1; rs1_data_in = pick_val(); rs2_data_in = pick_val();
                if ($urandom_range(0, 1) == 0) begin
                    md_en_in = 1; funct3_in = 3'($urandom_range(0, 3));
                    q.push_back(ref_mul(funct3_in, rs1_data_in, rs2_data_in));
                end else begin
                    alu_op_in = 4'($urandom_range(0, 10)); imm_in = $urandom;
                    alu_src_b_imm_in = 1'($urandom_range(0, 1));
                    q.push_back(ref_alu(int'(alu_op_in), rs1_data_in, alu_src_b_imm_in ? imm_in : rs2_data_in));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jump();
        test_mul();
        test_div();
        test_flush();
        test_stall();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
